// File: rtl/tour_pkg.sv
// Shared encoding for the knight's tour solver and the tour command sequencer:
// FSM states, board constants and the one-hot move geometry.
package tour_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        POSSIBLE,
        MAKE_MOVE,
        BACKUP,
        DONE
    } state_t;

    localparam int BOARD_DIM   = 5;
    localparam int NUM_MOVES   = 24;
    localparam int NUM_SQUARES = BOARD_DIM * BOARD_DIM;

    // Candidate scan runs from bit 0 up to bit 7.
    localparam logic [7:0] FIRST_TRY = 8'h01;
    localparam logic [7:0] LAST_TRY  = 8'h80;

    // Signed board limits for the 4-bit coordinate intermediates.
    localparam logic signed [3:0] COORD_MIN = 4'sd0;
    localparam logic signed [3:0] COORD_LIM = 4'sd5;

    // Column offset of a one-hot move; zero for a non one-hot code.
    function automatic logic signed [3:0] off_x(input logic [7:0] mv);
        logic signed [3:0] d;
        case (mv)
            8'h01:   d = -4'sd1;
            8'h02:   d =  4'sd1;
            8'h04:   d = -4'sd2;
            8'h08:   d = -4'sd2;
            8'h10:   d = -4'sd1;
            8'h20:   d =  4'sd1;
            8'h40:   d =  4'sd2;
            8'h80:   d =  4'sd2;
            default: d =  4'sd0;
        endcase
        return d;
    endfunction

    // Row offset of a one-hot move; zero for a non one-hot code.
    function automatic logic signed [3:0] off_y(input logic [7:0] mv);
        logic signed [3:0] d;
        case (mv)
            8'h01:   d =  4'sd2;
            8'h02:   d =  4'sd2;
            8'h04:   d =  4'sd1;
            8'h08:   d = -4'sd1;
            8'h10:   d = -4'sd2;
            8'h20:   d = -4'sd2;
            8'h40:   d = -4'sd1;
            8'h80:   d =  4'sd1;
            default: d =  4'sd0;
        endcase
        return d;
    endfunction

    // True when a signed coordinate pair lies on the 5x5 board.
    function automatic logic on_board(input logic signed [3:0] x,
                                      input logic signed [3:0] y);
        return (x >= COORD_MIN) && (x < COORD_LIM) &&
               (y >= COORD_MIN) && (y < COORD_LIM);
    endfunction

    // Linear square number x*5+y, used to address the visited bitmap.
    function automatic logic [4:0] sq_idx(input logic [2:0] x, input logic [2:0] y);
        return 5'(x) * 5'(BOARD_DIM) + 5'(y);
    endfunction

    // Mask of the eight moves whose target stays on the board from (x, y).
    function automatic logic [7:0] calc_poss(input logic [2:0] x, input logic [2:0] y);
        logic [7:0] mask;
        logic [7:0] mv;
        mask = 8'h00;
        for (int i = 0; i < 8; i++) begin
            mv      = FIRST_TRY << i;
            mask[i] = on_board($signed({1'b0, x}) + off_x(mv),
                               $signed({1'b0, y}) + off_y(mv));
        end
        return mask;
    endfunction

endpackage

// File: rtl/knight_tour_solver.sv
// Knight's tour solver for a 5x5 board. On go it runs an exhaustive
// depth-first search from the start square, trying moves in ascending bit
// order, and leaves the 24 one-hot moves in last_move for the sequencer to
// read back by index. done pulses on success, fail when the search is
// exhausted or the start square is off the board.
module knight_tour_solver
    import tour_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [2:0] x_start,
    input  logic [2:0] y_start,
    input  logic [4:0] indx,
    output logic [7:0] move,
    output logic       done,
    output logic       fail
);

    state_t                 state;
    logic [NUM_SQUARES-1:0] visited;
    logic [2:0]             xx;
    logic [2:0]             yy;
    logic [4:0]             move_num;
    logic [7:0]             last_move  [NUM_MOVES];
    logic [7:0]             poss_moves [NUM_MOVES];
    logic [7:0]             try;

    // Forward step: target of the candidate currently held in try.
    logic signed [3:0] fwd_x;
    logic signed [3:0] fwd_y;
    logic [4:0]        fwd_sq;
    logic [7:0]        cand_mask;
    logic              fwd_ok;

    // Backward step: undo the move that brought us to the current level.
    logic [4:0]        prev_num;
    logic [7:0]        prev_move;
    logic signed [3:0] back_x;
    logic signed [3:0] back_y;
    logic              back_ok;

    logic [4:0]        cur_sq;
    logic              last_level;

    assign cand_mask = poss_moves[move_num] & try;
    assign fwd_x     = $signed({1'b0, xx}) + off_x(try);
    assign fwd_y     = $signed({1'b0, yy}) + off_y(try);
    assign fwd_sq    = sq_idx(fwd_x[2:0], fwd_y[2:0]);
    // The bounds test guards the visited lookup so an off-board target is
    // never taken even if its wrapped square number happens to be free.
    assign fwd_ok    = (cand_mask != 8'h00) && on_board(fwd_x, fwd_y) &&
                       !visited[fwd_sq];

    assign prev_num  = (move_num == 5'd0) ? 5'd0 : move_num - 5'd1;
    assign prev_move = last_move[prev_num];
    assign back_x    = $signed({1'b0, xx}) - off_x(prev_move);
    assign back_y    = $signed({1'b0, yy}) - off_y(prev_move);
    assign back_ok   = on_board(back_x, back_y);

    assign cur_sq     = sq_idx(xx, yy);
    assign last_level = (move_num == 5'(NUM_MOVES - 1));

    // Zero-latency read port for the sequencer; out-of-range indices read 0.
    assign move = (indx < 5'(NUM_MOVES)) ? last_move[indx] : 8'h00;

    // Search FSM and datapath: one state register, registered done/fail pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            visited  <= '0;
            xx       <= 3'd0;
            yy       <= 3'd0;
            move_num <= 5'd0;
            try      <= 8'h00;
            done     <= 1'b0;
            fail     <= 1'b0;
            for (int i = 0; i < NUM_MOVES; i++) begin
                last_move[i]  <= 8'h00;
                poss_moves[i] <= 8'h00;
            end
        end else begin
            done <= 1'b0;
            fail <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        if ((x_start > 3'd4) || (y_start > 3'd4)) begin
                            // Bad start square: report and keep the old tour.
                            fail <= 1'b1;
                        end else begin
                            xx    <= x_start;
                            yy    <= y_start;
                            state <= INIT;
                        end
                    end
                end

                INIT: begin
                    visited         <= '0;
                    visited[cur_sq] <= 1'b1;
                    for (int i = 0; i < NUM_MOVES; i++) begin
                        last_move[i] <= 8'h00;
                    end
                    move_num <= 5'd0;
                    state    <= POSSIBLE;
                end

                POSSIBLE: begin
                    poss_moves[move_num] <= calc_poss(xx, yy);
                    try                  <= FIRST_TRY;
                    state                <= MAKE_MOVE;
                end

                MAKE_MOVE: begin
                    if (fwd_ok) begin
                        visited[fwd_sq]     <= 1'b1;
                        xx                  <= fwd_x[2:0];
                        yy                  <= fwd_y[2:0];
                        last_move[move_num] <= try;
                        if (last_level) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            move_num <= move_num + 5'd1;
                            state    <= POSSIBLE;
                        end
                    end else if (try != LAST_TRY) begin
                        try <= try << 1;
                    end else begin
                        state <= BACKUP;
                    end
                end

                BACKUP: begin
                    // Level 0 exhausted means no tour exists from this start.
                    // A step back off the board can only follow corruption,
                    // so it is treated the same way rather than stored.
                    if ((move_num == 5'd0) || !back_ok) begin
                        fail  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        visited[cur_sq] <= 1'b0;
                        xx              <= back_x[2:0];
                        yy              <= back_y[2:0];
                        move_num        <= prev_num;
                        // A level whose last taken move was bit 7 has no
                        // candidates left, so keep unwinding.
                        if (prev_move != LAST_TRY) begin
                            try   <= prev_move << 1;
                            state <= MAKE_MOVE;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knight_tour_solver.sv
// Bench for knight_tour_solver: a plain depth-first tour model supplies the
// expected move lists, and tour properties (one-hot, on-board replay, full
// coverage) are checked independently of the model.
module tb_knight_tour_solver;
    import tour_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       go = 1'b0;
    logic [2:0] x_start = 3'd0;
    logic [2:0] y_start = 3'd0;
    logic [4:0] indx = 5'd0;
    logic [7:0] move;
    logic       done;
    logic       fail;

    int total = 0;
    int bad   = 0;

    // Clock and DUT.
    always #5 clk = ~clk;

    knight_tour_solver dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (go),
        .x_start (x_start),
        .y_start (y_start),
        .indx    (indx),
        .move    (move),
        .done    (done),
        .fail    (fail)
    );

    // Knight geometry straight from the move table.
    int dx_tab [8] = '{-1,  1, -2, -2, -1,  1,  2,  2};
    int dy_tab [8] = '{ 2,  2,  1, -1, -2, -2, -1,  1};

    logic [7:0] model_seq [24];
    logic [7:0] act_seq   [32];
    logic [7:0] exp_q [$];

    // Pulse monitor: flags done/fail when not expected or wider than a cycle.
    bit   allow_done = 1'b0;
    bit   allow_fail = 1'b0;
    logic done_q = 1'b0;
    logic fail_q = 1'b0;
    int   stray = 0;

    always @(negedge clk) begin
        if (done === 1'b1 && !allow_done) stray++;
        if (fail === 1'b1 && !allow_fail) stray++;
        if (done === 1'b1 && done_q === 1'b1) stray++;
        if (fail === 1'b1 && fail_q === 1'b1) stray++;
        done_q = done;
        fail_q = fail;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference search: classic DFS over squares, directions tried 0..7.
    task automatic model_run(input int sx, input int sy, output bit found);
        int px [25];
        int py [25];
        int d  [25];
        bit vis [5][5];
        int lvl;
        int tx;
        int ty;
        bit stepped;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                vis[i][j] = 1'b0;
        for (int i = 0; i < 24; i++) model_seq[i] = 8'h00;
        px[0] = sx;
        py[0] = sy;
        d[0]  = 0;
        vis[sx][sy] = 1'b1;
        lvl   = 0;
        found = 1'b0;
        tx    = 0;
        ty    = 0;
        while (1) begin
            if (lvl == 24) begin
                found = 1'b1;
                break;
            end
            stepped = 1'b0;
            while (d[lvl] < 8 && !stepped) begin
                tx = px[lvl] + dx_tab[d[lvl]];
                ty = py[lvl] + dy_tab[d[lvl]];
                if (tx >= 0 && tx < 5 && ty >= 0 && ty < 5 && !vis[tx][ty])
                    stepped = 1'b1;
                else
                    d[lvl]++;
            end
            if (stepped) begin
                model_seq[lvl] = 8'h01 << d[lvl];
                px[lvl+1] = tx;
                py[lvl+1] = ty;
                vis[tx][ty] = 1'b1;
                d[lvl+1] = 0;
                lvl++;
            end else begin
                if (lvl == 0) break;
                vis[px[lvl]][py[lvl]] = 1'b0;
                lvl--;
                d[lvl]++;
            end
        end
    endtask

    task automatic pulse_go(input int x, input int y);
        @(negedge clk);
        x_start = 3'(x);
        y_start = 3'(y);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    // Waits for done or fail; optionally re-pulses go while the search runs.
    task automatic wait_result(input int limit, input bit disturb,
                               output bit got_done, output bit got_fail);
        got_done = 1'b0;
        got_fail = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            go = 1'b0;
            if (done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            if (fail === 1'b1) begin
                got_fail = 1'b1;
                break;
            end
            if (disturb && (c == 2 || c == 9 || c == 40 || c == 333 || c == 2500))
                go = 1'b1;
        end
        go = 1'b0;
    endtask

    // Scoreboard read-back of all 32 indices plus model-free tour checks.
    task automatic read_and_check(input string tag, input int sx, input int sy);
        bit seen [5][5];
        int px;
        int py;
        int k;
        int cnt;
        int oh;
        bit on_ok;
        logic [7:0] bitv;
        for (int i = 0; i < 32; i++) begin
            if (i < 24) exp_q.push_back(model_seq[i]);
            else        exp_q.push_back(8'h00);
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            indx = 5'(i);
            #1;
            act_seq[i] = move;
            check({tag, "_move"}, 32'(move), 32'(exp_q.pop_front()));
        end
        oh = 0;
        for (int i = 0; i < 24; i++) if ($onehot(act_seq[i])) oh++;
        check({tag, "_onehot"}, 32'(oh), 32'd24);
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                seen[i][j] = 1'b0;
        px = sx;
        py = sy;
        seen[px][py] = 1'b1;
        cnt = 1;
        on_ok = 1'b1;
        for (int i = 0; i < 24; i++) begin
            k = -1;
            for (int b = 0; b < 8; b++) begin
                bitv = 8'h01 << b;
                if (act_seq[i] == bitv) k = b;
            end
            if (k < 0) begin
                on_ok = 1'b0;
                break;
            end
            px = px + dx_tab[k];
            py = py + dy_tab[k];
            if (px < 0 || px > 4 || py < 0 || py > 4) begin
                on_ok = 1'b0;
                break;
            end
            if (!seen[px][py]) begin
                seen[px][py] = 1'b1;
                cnt++;
            end
        end
        check({tag, "_replay_on_board"}, 32'(on_ok), 32'd1);
        check({tag, "_squares_covered"}, 32'(cnt), 32'd25);
    endtask

    task automatic solve_and_check(input string tag, input int sx, input int sy,
                                   input bit disturb);
        bit got_done;
        bit got_fail;
        allow_done = 1'b1;
        pulse_go(sx, sy);
        wait_result(5_000_000, disturb, got_done, got_fail);
        check({tag, "_done"}, 32'(got_done), 32'd1);
        check({tag, "_no_fail"}, 32'(got_fail), 32'd0);
        @(negedge clk);
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_idle_after"}, 32'(dut.state), 32'(IDLE));
        allow_done = 1'b0;
        read_and_check(tag, sx, sy);
    endtask

    // Directed test sequence and final report.
    initial begin
        bit found;
        bit got_done;
        bit got_fail;
        int oor_x [2] = '{5, 0};
        int oor_y [2] = '{2, 7};

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        indx = 5'd0;
        #1;
        check("reset_done", 32'(done), 32'd0);
        check("reset_fail", 32'(fail), 32'd0);
        check("reset_move0", 32'(move), 32'd0);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // Model pins: centre is 8-fold symmetric so the first move is bit 0;
        // from the corner, diagonal symmetry gives tours via (1,2) = bit 1.
        model_run(2, 2, found);
        check("model_found_c22", 32'(found), 32'd1);
        check("model_first_c22", 32'(model_seq[0]), 32'h01);
        solve_and_check("c22", 2, 2, 1'b0);

        repeat (10000) @(negedge clk);
        read_and_check("c22_hold", 2, 2);
        check("stray_after_hold", 32'(stray), 32'd0);

        // Off-board start squares: immediate fail, stored tour untouched.
        allow_fail = 1'b1;
        for (int t = 0; t < 2; t++) begin
            pulse_go(oor_x[t], oor_y[t]);
            check("oor_fail", 32'(fail), 32'd1);
            check("oor_no_done", 32'(done), 32'd0);
            check("oor_idle", 32'(dut.state), 32'(IDLE));
            @(negedge clk);
            check("oor_fail_width", 32'(fail), 32'd0);
        end
        allow_fail = 1'b0;
        indx = 5'd0;
        #1;
        check("oor_tour_kept", 32'(move), 32'(model_seq[0]));

        model_run(0, 0, found);
        check("model_found_c00", 32'(found), 32'd1);
        check("model_first_c00", 32'(model_seq[0]), 32'h02);
        solve_and_check("c00_disturbed", 0, 0, 1'b1);
        check("c00_first_legal",
              32'((act_seq[0] == 8'h02) || (act_seq[0] == 8'h80)), 32'd1);

        // Reset during a long search: outputs and store cleared.
        pulse_go(1, 0);
        repeat (500) @(negedge clk);
        check("midrun_busy", 32'(dut.state != IDLE), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_done", 32'(done), 32'd0);
        check("midrun_rst_fail", 32'(fail), 32'd0);
        check("midrun_rst_state", 32'(dut.state), 32'(IDLE));
        for (int i = 0; i < 32; i++) begin
            indx = 5'(i);
            #1;
            check("midrun_rst_move", 32'(move), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        model_run(2, 2, found);
        solve_and_check("c22_after_rst", 2, 2, 1'b0);
        check("stray_mid", 32'(stray), 32'd0);

        // Odd-colour start: 13 even vs 12 odd squares, so no tour exists.
        allow_fail = 1'b1;
        pulse_go(1, 0);
        wait_result(50_000_000, 1'b0, got_done, got_fail);
        check("c10_fail", 32'(got_fail), 32'd1);
        check("c10_no_done", 32'(got_done), 32'd0);
        @(negedge clk);
        check("c10_idle", 32'(dut.state), 32'(IDLE));
        check("c10_fail_width", 32'(fail), 32'd0);
        allow_fail = 1'b0;
        check("stray_final", 32'(stray), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
